// File: rtl/dir_req_sequencer.sv
// Round-robin directory request sequencer: one outstanding directory op, pulsed request, valid/ready response.
// Optional ack timeout enabled by defining DIR_SEQ_TIMEOUT_EN.

package param_pkg;
  localparam int DCACHE_INDEX_WIDTH = 8;
  localparam int DCACHE_TAG_WIDTH   = 8;
  localparam int N_CPU              = 4;
  localparam int CPU_ID_WIDTH       = 2;

  typedef enum logic [1:0] {
    READ_OP       = 2'd0,
    WRITE_OP      = 2'd1,
    EVICT_OP      = 2'd2,
    WRITE_BACK_OP = 2'd3
  } op_dir_t;
endpackage

module dir_req_sequencer
  import param_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SRC_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [N_REQ-1:0]                         req_valid_i,
  output logic [N_REQ-1:0]                         req_ready_o,
  input  op_dir_t [N_REQ-1:0]                      req_op_i,
  input  logic [N_REQ-1:0][DCACHE_INDEX_WIDTH-1:0] req_index_i,
  input  logic [N_REQ-1:0][DCACHE_TAG_WIDTH-1:0]   req_tag_i,
  input  logic [N_REQ-1:0][CPU_ID_WIDTH-1:0]       req_cpu_id_i,
  output logic                                     rsp_valid_o,
  input  logic                                     rsp_ready_i,
  output logic [SRC_W-1:0]                         rsp_src_o,
  output logic [N_CPU-1:0]                         rsp_sharers_o,
  output logic                                     rsp_err_o,
  output logic                                     err_sticky_o,
  output logic                                     dir_req_o,
  output op_dir_t                                  dir_operation_o,
  output logic [DCACHE_INDEX_WIDTH-1:0]            dir_index_o,
  output logic [DCACHE_TAG_WIDTH-1:0]              dir_tag_o,
  output logic [CPU_ID_WIDTH-1:0]                  dir_cpu_id_o,
  input  logic [N_CPU-1:0]                         dir_sharers_i,
  input  logic                                     dir_ack_i
);

  if (N_REQ < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("dir_req_sequencer: N_REQ and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

  state_t           state;
  state_t           next_state;
  logic [SRC_W-1:0] last_grant;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand;
  logic             grant_found;
  logic             expired;

  // Search starts one past the previous winner so every source gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = SRC_W'((int'(last_grant) + i) % N_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    next_state  = state;
    req_ready_o = '0;
    rsp_valid_o = 1'b0;
    dir_req_o   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found && !reset) begin
          req_ready_o[grant_idx] = 1'b1;
          next_state             = ISSUE;
        end
      end
      ISSUE: begin
        dir_req_o  = 1'b1;
        next_state = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (dir_ack_i || expired) next_state = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= SRC_W'(N_REQ - 1);
      rsp_src_o       <= '0;
      rsp_sharers_o   <= '0;
      dir_operation_o <= READ_OP;
      dir_index_o     <= '0;
      dir_tag_o       <= '0;
      dir_cpu_id_o    <= '0;
    end else begin
      state <= next_state;
      // Operands are only loaded on handshake, so they stay frozen through ISSUE and WAIT_ACK.
      if (state == IDLE && grant_found) begin
        dir_operation_o <= req_op_i[grant_idx];
        dir_index_o     <= req_index_i[grant_idx];
        dir_tag_o       <= req_tag_i[grant_idx];
        dir_cpu_id_o    <= req_cpu_id_i[grant_idx];
        rsp_src_o       <= grant_idx;
        last_grant      <= grant_idx;
      end
      if (state == WAIT_ACK) begin
        if (dir_ack_i) rsp_sharers_o <= dir_sharers_i;
        else if (expired) rsp_sharers_o <= '0;
      end
    end
  end

`ifdef DIR_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign expired = (state == WAIT_ACK) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // An ack arriving in the expiry cycle takes precedence over the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt     <= '0;
      rsp_err_o    <= 1'b0;
      err_sticky_o <= 1'b0;
    end else begin
      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT_ACK && !expired) wait_cnt <= wait_cnt + 1'b1;
      if (state == WAIT_ACK) begin
        if (dir_ack_i) begin
          rsp_err_o <= 1'b0;
        end else if (expired) begin
          rsp_err_o    <= 1'b1;
          err_sticky_o <= 1'b1;
        end
      end
    end
  end
`else
  assign expired      = 1'b0;
  assign rsp_err_o    = 1'b0;
  assign err_sticky_o = 1'b0;
`endif

endmodule

// File: doc/dir_req_sequencer.md
# dir_req_sequencer

Initiator for the interconnect directory memory's request/ack interface. Accepts directory operations from `N_REQ` coherence-controller sources over valid/ready, arbitrates them round-robin, and drives one operation at a time into the directory. It pulses the directory request for exactly one cycle and holds the operands stable until ack. It returns the sharer vector to the originating source over a valid/ready response channel.

## Interface
Parameters (`DCACHE_INDEX_WIDTH`, `DCACHE_TAG_WIDTH`, `CPU_ID_WIDTH`, `N_CPU`, `op_dir_t` come from `param_pkg`):
- `N_REQ`, 2: number of requesting sources, at least 1.
- `TIMEOUT_CYCLES`, 16: cycles to wait for ack before aborting. Used only with `DIR_SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  N_REQ  per-source request valid.
- `req_ready_o`  out  N_REQ  per-source accept; one-hot or zero.
- `req_op_i`  in  N_REQ×op_dir_t  operation per source.
- `req_index_i`  in  N_REQ×DCACHE_INDEX_WIDTH  set index per source.
- `req_tag_i`  in  N_REQ×DCACHE_TAG_WIDTH  tag per source.
- `req_cpu_id_i`  in  N_REQ×CPU_ID_WIDTH  CPU id per source.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accept.
- `rsp_src_o`  out  $clog2(N_REQ) (min 1)  source the response belongs to.
- `rsp_sharers_o`  out  N_CPU  sharer vector captured at ack.
- `rsp_err_o`  out  1  operation aborted by timeout.
- `err_sticky_o`  out  1  set on any timeout; cleared only by reset.
- `dir_req_o`  out  1  directory request, one-cycle pulse.
- `dir_operation_o`  out  op_dir_t  operation to the directory.
- `dir_index_o`  out  DCACHE_INDEX_WIDTH  index to the directory.
- `dir_tag_o`  out  DCACHE_TAG_WIDTH  tag to the directory.
- `dir_cpu_id_o`  out  CPU_ID_WIDTH  CPU id to the directory.
- `dir_sharers_i`  in  N_CPU  sharers from the directory; valid only with ack.
- `dir_ack_i`  in  1  directory completion, one cycle.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT_ACK`, `RESP`.
- `IDLE`:
  - The round-robin arbiter selects the first requesting source at or after `last_grant+1`, wrapping modulo `N_REQ`.
  - `req_ready_o[g]` = 1 for the winner only, combinationally from `req_valid_i`.
  - On handshake, op/index/tag/cpu_id are registered into the `dir_*_o` operand registers, `g` is registered as the source, `last_grant` is set to `g`, and the FSM moves to `ISSUE`.
- `ISSUE`: `dir_req_o`=1 for this cycle only; go to `WAIT_ACK`.
- `WAIT_ACK`:
  - `dir_req_o`=0; operands stay unchanged.
  - On `dir_ack_i`, capture `dir_sharers_i` into `rsp_sharers_o`, set `rsp_err_o`=0, go to `RESP`.
- `RESP`:
  - `rsp_valid_o`=1; `rsp_src_o`, `rsp_sharers_o`, `rsp_err_o` stay stable.
  - On `rsp_ready_i`, go to `IDLE`.
- `req_ready_o` is all-zero in every state except `IDLE`. At most one directory operation is outstanding.
- `dir_ack_i` outside `WAIT_ACK` is ignored and causes no state change.
- Operands never change between `ISSUE` and leaving `WAIT_ACK`. The directory reads tag, cpu_id and index in its handle cycle and writes on ack.
- After ack there is at least one cycle before the next `dir_req_o`. This guarantees the directory's write lands before the next read of the same index.

## Timing
- Reset: FSM to `IDLE`.
  - All outputs are 0: `req_ready_o`, `rsp_valid_o`, `rsp_src_o`, `rsp_sharers_o`, `rsp_err_o`, `err_sticky_o`, `dir_req_o`, `dir_operation_o`, `dir_index_o`, `dir_tag_o`, `dir_cpu_id_o`.
  - `last_grant` = `N_REQ-1`, so source 0 wins first.
  - Reset mid-operation drops the operation with no response. The directory is reset in the same cycle.
- Latency with request handshake at edge T:
  - `dir_req_o` high in cycle T+1.
  - Earliest ack in T+2.
  - `rsp_valid_o` from T+3.
  - With `rsp_ready_i` held high, the next handshake is possible at T+4. Peak throughput is one operation per 4 cycles.
- With `rsp_ready_i`=0, the FSM stays in `RESP` indefinitely. Response fields hold.
- A source that drops `req_valid_i` before handshake loses nothing; no state is kept for it.

## Configuration
- `DIR_SEQ_TIMEOUT_EN` defined:
  - A counter runs in `WAIT_ACK`; it clears on entry to `WAIT_ACK`.
  - When the count reaches `TIMEOUT_CYCLES` with no ack, go to `RESP` with `rsp_err_o`=1, `rsp_sharers_o`=0, and set `err_sticky_o`.
  - Ack in the same cycle as expiry wins: normal response, no error.
  - This covers EVICT/WRITE_BACK on a directory miss, which never acks.
- `DIR_SEQ_TIMEOUT_EN` undefined:
  - No counter; `WAIT_ACK` waits indefinitely.
  - `rsp_err_o` and `err_sticky_o` are tied to 0.

## Test plan
- Single READ_OP from source 0 (index 5, tag 0x12, cpu 1); directory acks at T+2 with sharers 0b0110 -> `dir_req_o` high in T+1 only, operands stable T+1..T+2, `rsp_valid_o` at T+3 with src 0, sharers 0b0110, err 0.
- Sources 0 and 1 both held valid for 4 operations -> grants in order 0,1,0,1; never two `req_ready_o` bits high; exactly one `dir_req_o` pulse per operation.
- `rsp_ready_i` held 0 for 10 cycles after ack -> `rsp_valid_o` and all fields stable; no `req_ready_o`; no `dir_req_o`.
- Spurious `dir_ack_i` in `IDLE` and in `ISSUE` -> no state change, no response.
- Macro defined, `TIMEOUT_CYCLES`=16, EVICT_OP never acked -> response 16 cycles after entering `WAIT_ACK` with err 1, sharers 0; `err_sticky_o`=1 until reset. Ack on cycle 16 -> err 0.
- `reset` asserted in `WAIT_ACK` -> next cycle all outputs 0 and FSM in `IDLE`; a pending source 1 is granted after deassertion only if it is the sole requester; otherwise source 0 wins.
